// File: rtl/shift_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : shift_pkg                                                  |
// | Description : Shared widths, FIFO entry layout and push-side clamping.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 5;
    localparam int CTRL_W = 4;
    localparam int TAG_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] amt;
        logic [TAG_W-1:0]  tag;
        logic              sat;
    } fifo_entry_t;

    // Shifting a 16-bit value by 15 already yields all sign bits, so any
    // amount of 16 or more collapses to 15 with the sat flag recorded.
    function automatic fifo_entry_t make_entry(
        input logic [DATA_W-1:0] data,
        input logic [AMT_W-1:0]  amt,
        input logic [TAG_W-1:0]  tag
    );
        fifo_entry_t e;
        e.data = data;
        e.sat  = amt[AMT_W-1];
        e.amt  = e.sat ? {CTRL_W{1'b1}} : amt[CTRL_W-1:0];
        e.tag  = tag;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_req_fifo.sv
// +--------------------------------------------------------------------------+
// | Module      : shift_req_fifo                                             |
// | Description : Synchronous request FIFO with registered pointers.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_req_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  fifo_entry_t entry_i,
    input  logic        pop_i,
    output fifo_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_req_stage.sv
// +--------------------------------------------------------------------------+
// | Module      : shift_req_stage                                            |
// | Description : Request FIFO feeding an external arithmetic-right barrel   |
// |               shifter, with a registered valid/ready result slot.        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_req_stage
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [AMT_W-1:0]  req_amt,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] sh_in,
    output logic [CTRL_W-1:0] sh_ctrl,
    input  logic [DATA_W-1:0] sh_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_sat
);

    fifo_entry_t       w_head;
    fifo_entry_t       w_entry;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q,   rsp_tag_d;
    logic              rsp_sat_q,   rsp_sat_d;

    assign w_entry   = make_entry(req_data, req_amt, req_tag);
    assign req_ready = !w_fifo_full;
    assign w_push    = req_valid && !w_fifo_full;
    assign w_pop     = !w_fifo_empty && (!rsp_valid_q || rsp_ready);

    shift_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .entry_i (w_entry),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // FIFO storage is not reset, so the shifter is fed zeros when empty.
    assign sh_in   = w_fifo_empty ? '0 : w_head.data;
    assign sh_ctrl = w_fifo_empty ? '0 : w_head.amt;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_sat_d   = rsp_sat_q;
        if (w_pop) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sh_out;
            rsp_tag_d   = w_head.tag;
            rsp_sat_d   = w_head.sat;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_sat_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_sat_q   <= rsp_sat_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_sat   = rsp_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_req_stage.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_shift_req_stage                                         |
// | Description : Scoreboard bench for shift_req_stage with a behavioural    |
// |               arithmetic-right barrel shifter on the sh_* port.          |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_shift_req_stage;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  t;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [4:0]  req_amt = '0;
    logic [3:0]  req_tag = '0;
    logic [15:0] sh_in;
    logic [3:0]  sh_ctrl;
    logic [15:0] sh_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_sat;

    logic        rsp_ready_dir = 1'b0;
    logic        rnd_bit = 1'b0;
    logic        rnd_mode = 1'b0;

    exp_t        sb[$];
    int          resp_cyc[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          stalls = 0;

    logic [15:0] stream_exp [16] = '{
        16'hF0F0, 16'hF878, 16'hFC3C, 16'hFE1E, 16'hFF0F, 16'hFF87, 16'hFFC3, 16'hFFE1,
        16'hFFF0, 16'hFFF8, 16'hFFFC, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF
    };

    assign sh_out    = 16'($signed(sh_in) >>> sh_ctrl);
    assign rsp_ready = rnd_mode ? rnd_bit : rsp_ready_dir;

    shift_req_stage #(
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_tag   (req_tag),
        .sh_in     (sh_in),
        .sh_ctrl   (sh_ctrl),
        .sh_out    (sh_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_sat   (rsp_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [4:0] a);
        logic signed [15:0] s;
        s = d;
        return 16'(s >>> a);
    endfunction

    // Response monitor: handshake seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got tag 0x%0h data 0x%0h, required no response",
                         rsp_tag, rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.d));
                check("rsp_tag", 32'(rsp_tag), 32'(e.t));
                check("rsp_sat", 32'(rsp_sat), 32'(e.s));
                resp_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [4:0] a, input logic [3:0] t,
                        input logic [15:0] ed, input logic es);
        int wait_n;
        exp_t e;
        wait_n = 0;
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_tag   = t;
        @(negedge clk);
        while (!req_ready) begin
            wait_n++;
            if (wait_n > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got req_ready 0 for %0d cycles, required 1", wait_n);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.d = ed;
        e.t = t;
        e.s = es;
        sb.push_back(e);
        stalls += wait_n;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'h0);
        check("rst_rsp_sat", 32'(rsp_sat), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_sh_in", 32'(sh_in), 32'h0);
        check("rst_sh_ctrl", 32'(sh_ctrl), 32'h0);
        @(posedge clk);
        #1 rsp_ready_dir = 1'b1;

        // Basic shift and one-cycle latency
        send(16'h8000, 5'd3, 4'h1, 16'hF000, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        check("lat_valid_early", 32'(rsp_valid), 32'd0);
        check("lat_sh_in", 32'(sh_in), 32'h8000);
        check("lat_sh_ctrl", 32'(sh_ctrl), 32'h3);
        @(negedge clk);
        check("lat_valid_next", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;

        // Saturation boundaries
        send(16'h7FFF, 5'd20, 4'h2, 16'h0000, 1'b1);
        send(16'h8001, 5'd31, 4'h3, 16'hFFFF, 1'b1);
        send(16'h1234, 5'd16, 4'h4, 16'h0000, 1'b1);
        send(16'h8000, 5'd15, 4'h5, 16'hFFFF, 1'b0);
        send(16'h4000, 5'd0,  4'h6, 16'h4000, 1'b0);
        req_valid = 1'b0;
        drain(20);

        // Backpressure: output slot plus two FIFO entries, fourth must stall
        @(posedge clk);
        #1 rsp_ready_dir = 1'b0;
        send(16'h0F00, 5'd4, 4'h7, 16'h00F0, 1'b0);
        send(16'hF00F, 5'd1, 4'h8, 16'hF807, 1'b0);
        send(16'h0001, 5'd0, 4'h9, 16'h0001, 1'b0);
        req_valid = 1'b1;
        req_data  = 16'hFFFF;
        req_amt   = 5'd8;
        req_tag   = 4'hA;
        @(negedge clk);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_tag", 32'(rsp_tag), 32'h7);
        check("bp_rsp_data", 32'(rsp_data), 32'h00F0);
        @(negedge clk);
        check("bp_hold_tag", 32'(rsp_tag), 32'h7);
        check("bp_hold_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rsp_ready_dir = 1'b1;
        send(16'hFFFF, 5'd8, 4'hA, 16'hFFFF, 1'b0);
        req_valid = 1'b0;
        drain(20);

        // Streaming at full rate
        @(posedge clk);
        #1;
        resp_cyc.delete();
        stalls = 0;
        for (int k = 0; k < 16; k++) begin
            send(16'hF0F0, 5'(k), 4'(k), stream_exp[k], 1'b0);
        end
        req_valid = 1'b0;
        drain(20);
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_count", 32'(resp_cyc.size()), 32'd16);
        if (resp_cyc.size() >= 16) begin
            check("stream_span", 32'(resp_cyc[resp_cyc.size()-1] - resp_cyc[0]), 32'd15);
        end

        // Reset with FIFO full and a result held
        @(posedge clk);
        #1 rsp_ready_dir = 1'b0;
        send(16'h1111, 5'd1, 4'hB, 16'h0888, 1'b0);
        send(16'h2222, 5'd2, 4'hC, 16'h0888, 1'b0);
        send(16'h3333, 5'd3, 4'hD, 16'h0666, 1'b0);
        req_valid = 1'b1;
        req_data  = 16'h5555;
        req_amt   = 5'd1;
        req_tag   = 4'hE;
        @(negedge clk);
        check("pre_rst_full", 32'(req_ready), 32'd0);
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rsp_ready_dir = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_data", 32'(rsp_data), 32'h0);
        check("mid_rst_tag", 32'(rsp_tag), 32'h0);
        check("mid_rst_sat", 32'(rsp_sat), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_sh_in", 32'(sh_in), 32'h0);
        repeat (6) @(negedge clk);
        check("mid_rst_no_stale", 32'(rsp_valid), 32'd0);

        // Random backpressure against the reference shift
        @(posedge clk);
        #1 rnd_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] d;
            logic [4:0]  a;
            d = 16'($urandom);
            a = 5'($urandom_range(0, 31));
            send(d, a, 4'(i), ref_shift(d, a), a >= 5'd16);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        drain(500);
        rnd_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_req_stage.md
SHIFT_REQ_STAGE -- requirements
Module: shift_req_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, request FIFO entries (power of two, 2..8).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  request offered.
REQ-005 SHALL have port req_ready  out  1  request FIFO can accept.
REQ-006 SHALL have port req_data  in  16  operand.
REQ-007 SHALL have port req_amt  in  5  arithmetic-right shift amount, 0..31.
REQ-008 SHALL have port req_tag  in  4  opaque ID, returned with result.
REQ-009 SHALL have port sh_in  out  16  operand to 16-bit arithmetic-right barrel shifter.
REQ-010 SHALL have port sh_ctrl  out  4  shift amount to barrel shifter.
REQ-011 SHALL have port sh_out  in  16  combinational result from barrel shifter.
REQ-012 SHALL have port rsp_valid  out  1  result held.
REQ-013 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-014 SHALL have port rsp_data  out  16  shifted result.
REQ-015 SHALL have port rsp_tag  out  4  tag of result.
REQ-016 SHALL have port rsp_sat  out  1  amount was clamped (req_amt >= 16).

Function
REQ-017 SHALL push {req_data, clamped amount, req_tag, sat flag} into FIFO when req_valid && req_ready at a clock edge.
REQ-018 SHALL clamp req_amt >= 16 to 15 at push and set sat flag; result is all sign bits, matching true arithmetic shift by >= 16.
REQ-019 SHALL drive req_ready = !fifo_full, independent of same-cycle pop (no full-FIFO pass-through).
REQ-020 SHALL drive sh_in/sh_ctrl combinationally from FIFO head; 0x0000/0x0 when FIFO empty.
REQ-021 SHALL load output register {sh_out, head tag, head sat} and pop FIFO when FIFO non-empty && (!rsp_valid || rsp_ready).
REQ-022 SHALL clear rsp_valid when rsp_valid && rsp_ready and FIFO empty; hold rsp_data/rsp_tag/rsp_sat unchanged while rsp_valid && !rsp_ready.
REQ-023 SHALL give latency of one cycle: request accepted at edge k, rsp_valid high from edge k+1 when output slot free.
REQ-024 SHALL sustain one result per cycle with req_valid and rsp_ready held high.
REQ-025 SHALL support simultaneous push and pop when not full; occupancy unchanged, order preserved.
REQ-026 SHALL wrap FIFO pointers modulo DEPTH; occupancy counter 0..DEPTH, no overflow or underflow.
REQ-027 SHALL return results in strict acceptance order; total in flight <= DEPTH+1.

Reset
REQ-028 SHALL, on rst_n low at an edge, clear FIFO pointers/occupancy, rsp_valid=0, rsp_data=0x0000, rsp_tag=0x0, rsp_sat=0; req_ready=1 from next cycle.
REQ-029 SHALL discard all in-flight requests on reset mid-operation; no rsp_valid for them after release.
REQ-030 SHALL ignore req_valid and rsp_ready while rst_n is low.

Structure
REQ-031 SHALL place width constants (DATA_W=16, AMT_W=5, CTRL_W=4, TAG_W=4) and the FIFO entry struct typedef in shared package shift_pkg.
REQ-032 SHALL implement storage as sub-module shift_req_fifo (parameter DEPTH, synchronous, registered pointers); shifter core external via sh_in/sh_ctrl/sh_out.

Verification
REQ-033 SHALL cover: push 0x8000 amt 3 tag 0x1, rsp_ready=1 -> next cycle rsp_data 0xF000, tag 0x1, sat 0.
REQ-034 SHALL cover: push 0x7FFF amt 20 -> rsp_data 0x0000, sat 1; push 0x8001 amt 31 -> rsp_data 0xFFFF, sat 1.
REQ-035 SHALL cover: rsp_ready=0, push 4 requests back-to-back -> 3 accepted (1 in output, 2 in FIFO), req_ready low on 4th; release rsp_ready -> results in tag order.
REQ-036 SHALL cover: streaming 16 requests (tags 0..15, amt 0..15 on 0xF0F0) with rsp_ready=1 -> one result per cycle, 0xF0F0 for amt 0, 0xFFFF for amt 15.
REQ-037 SHALL cover: rst_n low for one cycle with FIFO full and rsp_valid=1 -> all outputs zero, req_ready=1 next cycle, no stale responses.
REQ-038 SHALL cover: random rsp_ready toggling, 1000 requests vs. reference model -> zero data/tag/order mismatches.
